la_capture_rle_writer: RTL

Capture-side memory writer of the logic analyzer. It samples the probed word every clock, run-length encodes identical consecutive samples, and fills a circular pre-trigger queue until the trigger matches. It then fills the post-trigger region linearly and closes the capture with a tail descriptor line. Its write port drives the capture RAM that the dump/replay path later reads, with each line laid out as {repetition count, data}.

---
 rtl/la_capture_rle_writer_if.sv | 15 +
 rtl/la_capture_rle_writer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/la_capture_rle_writer_if.sv
// Capture RAM write port of the logic analyzer. The writer is the master; the
// RAM is the slave.
interface la_capture_rle_writer_if #(
  parameter int ADDR_BITS = 6,
  parameter int WORD_BITS = 24
);
  // Handshake: mem_we qualifies mem_addr/mem_wdata for exactly the cycle it is
  // high. The RAM always accepts, so there is no ready and no back-pressure.
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [WORD_BITS-1:0] mem_wdata;

  modport master (output mem_we, output mem_addr, output mem_wdata);
  modport slave  (input  mem_we, input  mem_addr, input  mem_wdata);
endinterface

// File: rtl/la_capture_rle_writer.sv
// Capture-side RLE writer: circular pre-trigger queue, linear post-trigger fill
// and a tail descriptor line. Define LA_RLE_COMPRESSION_EN to enable run merging.
module la_capture_rle_writer #(
  parameter int LA_DATA_INPUT_WORDLEN_BITS = 16,
  parameter int LA_MEM_ADDRESS_BITS        = 6,
  parameter int LA_BT_QUEUE_LINES          = 8,
  parameter int LA_IDENTICAL_SAMPLES_BITS  = 8,
  parameter logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] LA_TRIGGER_VALUE = 16'h0205,
  parameter logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] LA_TRIGGER_MASK  = 16'hFFFF
) (
  input  logic                                  clk_of_verifla,
  input  logic                                  reset,
  input  logic                                  arm,
  input  logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] data_in,
  la_capture_rle_writer_if.master               mem,
  output logic                                  la_trigger_matched,
  output logic                                  busy,
  output logic                                  capture_done,
  output logic [2:0]                            state_dbg
);

  localparam int DW = LA_DATA_INPUT_WORDLEN_BITS;
  localparam int AW = LA_MEM_ADDRESS_BITS;
  localparam int CW = LA_IDENTICAL_SAMPLES_BITS;

  localparam logic [AW-1:0] BT_LAST_LINE   = AW'(LA_BT_QUEUE_LINES - 1);
  localparam logic [AW-1:0] POST_FIRST     = AW'(LA_BT_QUEUE_LINES);
  localparam logic [AW-1:0] POST_LAST_LINE = AW'((1 << AW) - 2);
  localparam logic [AW-1:0] TAIL_LINE      = {AW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE        = CW'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    POST = 3'd2,
    TAIL = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  held_q, held_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  bt_ptr_q, bt_ptr_d;
  logic           wrapped_q, wrapped_d;
  logic [AW-1:0]  bt_last_q, bt_last_d;
  logic [AW-1:0]  post_ptr_q, post_ptr_d;
  logic           trig_q, trig_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [CW+DW-1:0] wdata_q, wdata_d;

  logic trigger_hit;
  logic extend_run;

  assign trigger_hit = ((data_in & LA_TRIGGER_MASK) == (LA_TRIGGER_VALUE & LA_TRIGGER_MASK));

`ifdef LA_RLE_COMPRESSION_EN
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  // A saturated run is closed and the same data restarts at count 1.
  assign extend_run = (data_in == held_q) && (cnt_q != CNT_MAX);
`else
  assign extend_run = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    held_d     = held_q;
    cnt_d      = cnt_q;
    bt_ptr_d   = bt_ptr_q;
    wrapped_d  = wrapped_q;
    bt_last_d  = bt_last_q;
    post_ptr_d = post_ptr_q;
    trig_d     = trig_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          held_d    = data_in;
          cnt_d     = CNT_ONE;
          bt_ptr_d  = '0;
          wrapped_d = 1'b0;
          trig_d    = 1'b0;
          state_d   = PRE;
        end
      end

      PRE: begin
        if (trigger_hit) begin
          // Forced flush keeps the pre-queue non-empty; the trigger sample opens POST.
          we_d       = 1'b1;
          addr_d     = bt_ptr_q;
          wdata_d    = {cnt_q, held_q};
          bt_last_d  = bt_ptr_q;
          held_d     = data_in;
          cnt_d      = CNT_ONE;
          trig_d     = 1'b1;
          post_ptr_d = POST_FIRST;
          state_d    = POST;
        end else if (extend_run) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          we_d    = 1'b1;
          addr_d  = bt_ptr_q;
          wdata_d = {cnt_q, held_q};
          held_d  = data_in;
          cnt_d   = CNT_ONE;
          if (bt_ptr_q == BT_LAST_LINE) begin
            bt_ptr_d  = '0;
            wrapped_d = 1'b1;
          end else begin
            bt_ptr_d = bt_ptr_q + AW'(1);
          end
        end
      end

      POST: begin
        if (extend_run) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          we_d       = 1'b1;
          addr_d     = post_ptr_q;
          wdata_d    = {cnt_q, held_q};
          held_d     = data_in;
          cnt_d      = CNT_ONE;
          post_ptr_d = post_ptr_q + AW'(1);
          // The run still pending after the last data line is dropped.
          if (post_ptr_q == POST_LAST_LINE) state_d = TAIL;
        end
      end

      TAIL: begin
        we_d    = 1'b1;
        addr_d  = TAIL_LINE;
        wdata_d = {wrapped_q, {(CW-1){1'b0}}, DW'(bt_last_q)};
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_of_verifla) begin
    if (reset) begin
      state_q    <= IDLE;
      held_q     <= '0;
      cnt_q      <= '0;
      bt_ptr_q   <= '0;
      wrapped_q  <= 1'b0;
      bt_last_q  <= '0;
      post_ptr_q <= '0;
      trig_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
      bt_ptr_q   <= bt_ptr_d;
      wrapped_q  <= wrapped_d;
      bt_last_q  <= bt_last_d;
      post_ptr_q <= post_ptr_d;
      trig_q     <= trig_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign mem.mem_we         = we_q;
  assign mem.mem_addr       = addr_q;
  assign mem.mem_wdata      = wdata_q;
  assign la_trigger_matched = trig_q;
  assign busy               = (state_q == PRE) || (state_q == POST) || (state_q == TAIL);
  assign capture_done       = (state_q == DONE);
  assign state_dbg          = state_q;

endmodule
